// File: rtl/sam_pkg.sv
// Shared parameters, state encodings and modular-multiply helper
// for the SAM serial RSA-style decoder.
package sam_pkg;

    localparam int KEY_W = 8;
    localparam int LEN_W = 4;
    localparam int CNT_W = 5;

    // Config chain holds {n, d, N}, first sampled bit ends up at the MSB.
    localparam int CFG_W = LEN_W + 2 * KEY_W;
    localparam int CC_W  = $clog2(CFG_W + 1);

    // Widest message the length field can describe.
    localparam int MSG_W = (1 << LEN_W) - 1;

    localparam int STEP_W = $clog2(KEY_W + 1);
    localparam int IDX_W  = $clog2(KEY_W);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } dec_state_t;

    typedef enum logic [1:0] {
        E_IDLE,
        E_LOAD,
        E_RUN,
        E_OUT
    } eng_state_t;

    // (a*b) mod n with a double-width product; moduli 0 and 1 give 0.
    function automatic logic [KEY_W-1:0] mulmod(
        input logic [KEY_W-1:0] a,
        input logic [KEY_W-1:0] b,
        input logic [KEY_W-1:0] n
    );
        logic [2*KEY_W-1:0] p;
        logic [2*KEY_W-1:0] q;
        p = {{KEY_W{1'b0}}, a} * {{KEY_W{1'b0}}, b};
        if (n[KEY_W-1:1] == '0) begin
            q = '0;
        end else begin
            q = p % {{KEY_W{1'b0}}, n};
        end
        return q[KEY_W-1:0];
    endfunction

endpackage

// File: rtl/sam_modexp.sv
// Modular exponentiation engine: latches m/d/N on start, loads,
// runs one square-and-multiply step per cycle (d LSB first), then
// shifts r out MSB first on msg with frame high.
// Ports: clk, reset, abort (mode), start, m, d, nmod -> msg, frame.
module sam_modexp
    import sam_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             abort,
    input  logic             start,
    input  logic [MSG_W-1:0] m,
    input  logic [KEY_W-1:0] d,
    input  logic [KEY_W-1:0] nmod,
    output logic             msg,
    output logic             frame
);

    eng_state_t        st;
    logic [MSG_W-1:0]  m_q;
    logic [KEY_W-1:0]  d_q;
    logic [KEY_W-1:0]  n_q;
    logic [KEY_W-1:0]  base;
    logic [KEY_W-1:0]  r;
    logic [STEP_W-1:0] cnt;

    logic [MSG_W-1:0]  m_rem;
    logic              n_big;

    assign n_big = |n_q[KEY_W-1:1];

    always_comb begin
        m_rem = '0;
        if (n_big) begin
            m_rem = m_q % {{(MSG_W-KEY_W){1'b0}}, n_q};
        end
    end

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            st    <= E_IDLE;
            m_q   <= '0;
            d_q   <= '0;
            n_q   <= '0;
            base  <= '0;
            r     <= '0;
            cnt   <= '0;
            msg   <= 1'b0;
            frame <= 1'b0;
        end else begin
            unique case (st)
                E_IDLE: begin
                    // Starts arriving while busy are simply dropped.
                    if (start) begin
                        m_q <= m;
                        d_q <= d;
                        n_q <= nmod;
                        st  <= E_LOAD;
                    end
                end
                E_LOAD: begin
                    base <= m_rem[KEY_W-1:0];
                    r    <= {{(KEY_W-1){1'b0}}, n_big};
                    cnt  <= '0;
                    st   <= E_RUN;
                end
                E_RUN: begin
                    if (d_q[cnt[IDX_W-1:0]]) begin
                        r <= mulmod(r, base, n_q);
                    end
                    base <= mulmod(base, base, n_q);
                    if (cnt == STEP_W'(KEY_W - 1)) begin
                        cnt <= '0;
                        st  <= E_OUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                E_OUT: begin
                    if (cnt == STEP_W'(KEY_W)) begin
                        frame <= 1'b0;
                        msg   <= 1'b0;
                        cnt   <= '0;
                        st    <= E_IDLE;
                    end else begin
                        frame <= 1'b1;
                        msg   <= r[KEY_W-1];
                        r     <= {r[KEY_W-2:0], 1'b0};
                        cnt   <= cnt + 1'b1;
                    end
                end
                default: st <= E_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sam_decoder.sv
// SAM decoder top: config shift-in, str edge detect, pulse-width bit
// decoder and message collector feeding the modexp engine.
// Ports: clk, reset, str, mode -> msg, frame.
module sam_decoder
    import sam_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic str,
    input  logic mode,
    output logic msg,
    output logic frame
);

    logic [CFG_W-1:0] cfg;
    logic [CC_W-1:0]  cfg_cnt;
    logic             prev_str;
    dec_state_t       st;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] l;
    logic [LEN_W-1:0] idx;
    logic [MSG_W-1:0] m;

    logic [LEN_W-1:0] n;
    logic [KEY_W-1:0] d;
    logic [KEY_W-1:0] nmod;

    logic             rise;
    logic             bit_ok;
    logic             bit_val;
    logic [LEN_W-1:0] idx_next;
    logic [MSG_W-1:0] m_next;
    logic             close;
    logic             done;

    assign n    = cfg[CFG_W-1 -: LEN_W];
    assign d    = cfg[2*KEY_W-1 -: KEY_W];
    assign nmod = cfg[KEY_W-1:0];

    // prev_str tracks str through config too, so a 1 held across the
    // mode fall is never seen as an edge.
    assign rise     = str & ~prev_str;
    assign bit_ok   = (h != l);
    assign bit_val  = (h > l);
    assign idx_next = idx + 1'b1;
    assign m_next   = {m[MSG_W-2:0], bit_val};
    assign close    = (st == LOW) && rise && !mode;
    assign done     = close && bit_ok && (idx_next == n);

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg      <= '0;
            cfg_cnt  <= '0;
            prev_str <= 1'b1;
            st       <= IDLE;
            h        <= '0;
            l        <= '0;
            idx      <= '0;
            m        <= '0;
        end else begin
            prev_str <= str;
            if (mode) begin
                if (cfg_cnt != CC_W'(CFG_W)) begin
                    cfg     <= {cfg[CFG_W-2:0], str};
                    cfg_cnt <= cfg_cnt + 1'b1;
                end
                st  <= IDLE;
                h   <= '0;
                l   <= '0;
                idx <= '0;
                m   <= '0;
            end else begin
                cfg_cnt <= '0;
                unique case (st)
                    IDLE: begin
                        if (rise && (n != '0)) begin
                            h   <= CNT_W'(1);
                            l   <= '0;
                            idx <= '0;
                            m   <= '0;
                            st  <= HIGH;
                        end
                    end
                    HIGH: begin
                        if (str) begin
                            h <= sat_inc(h);
                        end else begin
                            l  <= CNT_W'(1);
                            st <= LOW;
                        end
                    end
                    LOW: begin
                        if (!str) begin
                            l <= sat_inc(l);
                        end else begin
                            // Closing edge always opens the next bit.
                            h  <= CNT_W'(1);
                            l  <= '0;
                            st <= HIGH;
                            if (!bit_ok || done) begin
                                idx <= '0;
                                m   <= '0;
                            end else begin
                                idx <= idx_next;
                                m   <= m_next;
                            end
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

    sam_modexp u_modexp (
        .clk   (clk),
        .reset (reset),
        .abort (mode),
        .start (done),
        .m     (m_next),
        .d     (d),
        .nmod  (nmod),
        .msg   (msg),
        .frame (frame)
    );

endmodule

// File: tb/tb_sam_decoder.sv
// Directed scoreboard bench for sam_decoder: configures, sends
// pulse-width bits and checks latency and serial result.
module tb_sam_decoder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic str = 1'b0;
    logic mode = 1'b0;
    logic msg;
    logic frame;

    int checks = 0;
    int failures = 0;
    int frames = 0;
    logic frame_q = 1'b0;
    logic [7:0] sb[$];

    sam_decoder dut (
        .clk   (clk),
        .reset (reset),
        .str   (str),
        .mode  (mode),
        .msg   (msg),
        .frame (frame)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        frame_q <= frame;
        if (frame === 1'b1 && frame_q !== 1'b1) frames <= frames + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_modexp(input int mm, input int dd,
                                              input int nn);
        int r;
        if (nn < 2) return 8'h00;
        r = 1;
        for (int i = 0; i < dd; i++) r = (r * mm) % nn;
        return 8'(r);
    endfunction

    task automatic cfg(input logic [3:0] n, input logic [7:0] d,
                       input logic [7:0] nm);
        logic [19:0] v;
        v = {n, d, nm};
        mode = 1'b1;
        for (int i = 19; i >= 0; i--) begin
            str = v[i];
            tick();
        end
        mode = 1'b0;
    endtask

    task automatic send(input int hi, input int lo);
        str = 1'b1;
        repeat (hi) tick();
        str = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic expect_frame(input string tag, input int lat);
        int k;
        logic [7:0] got;
        logic [7:0] exp;
        exp = sb.pop_front();
        got = '0;
        k = 0;
        while (frame !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
        chk({tag, "_lat"}, k, lat);
        if (frame !== 1'b1) return;
        for (int i = 7; i >= 0; i--) begin
            chk({tag, "_frame"}, frame, 1);
            got[i] = msg;
            tick();
        end
        chk({tag, "_fend"}, frame, 0);
        chk({tag, "_mend"}, msg, 0);
        chk({tag, "_res"}, got, exp);
    endtask

    initial begin
        int f0;
        int k;
        repeat (3) tick();
        chk("rst_frame", frame, 0);
        chk("rst_msg", msg, 0);
        reset = 1'b0;
        tick();

        // 7^255 mod 255
        cfg(4'd3, 8'hFF, 8'hFF);
        str = 1'b0;
        tick();
        send(17, 10);
        send(17, 10);
        send(17, 10);
        str = 1'b1;
        sb.push_back(ref_modexp(7, 255, 255));
        expect_frame("pow255", 11);

        // 5^3 mod 13
        cfg(4'd3, 8'h03, 8'h0D);
        str = 1'b0;
        tick();
        send(12, 6);
        send(6, 12);
        send(12, 6);
        str = 1'b1;
        sb.push_back(ref_modexp(5, 3, 13));
        expect_frame("pow3", 11);

        // Equal H/L mid-message discards and restarts
        cfg(4'd3, 8'h03, 8'h0D);
        str = 1'b0;
        tick();
        send(12, 6);
        send(8, 8);
        send(12, 6);
        send(6, 12);
        send(12, 6);
        str = 1'b1;
        sb.push_back(ref_modexp(5, 3, 13));
        expect_frame("inval", 11);

        // Modulus 1 gives zero
        cfg(4'd2, 8'h05, 8'h01);
        str = 1'b0;
        tick();
        send(12, 6);
        send(6, 12);
        str = 1'b1;
        sb.push_back(ref_modexp(2, 5, 1));
        expect_frame("mod1", 11);

        // Reset during frame
        cfg(4'd1, 8'h01, 8'hFF);
        str = 1'b0;
        tick();
        send(6, 3);
        str = 1'b1;
        k = 0;
        while (frame !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
        chk("rstf_lat", k, 11);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("rstf_frame", frame, 0);
        chk("rstf_msg", msg, 0);
        reset = 1'b0;
        f0 = frames;
        str = 1'b0;
        tick();
        repeat (5) send(6, 3);
        str = 1'b1;
        repeat (30) tick();
        chk("rstf_quiet", frames, f0);

        // Last config bit 1 held across mode fall: no edge
        cfg(4'd1, 8'h01, 8'h0F);
        tick();
        tick();
        str = 1'b0;
        repeat (3) tick();
        send(10, 4);
        str = 1'b1;
        sb.push_back(ref_modexp(1, 1, 15));
        expect_frame("noedge", 11);

        // Saturated 40/33 pulse counts as H==L
        cfg(4'd2, 8'h01, 8'hFF);
        str = 1'b0;
        tick();
        send(40, 33);
        send(12, 6);
        send(6, 12);
        str = 1'b1;
        sb.push_back(ref_modexp(2, 1, 255));
        expect_frame("sat", 11);

        // Second message completing while busy is dropped
        cfg(4'd1, 8'h01, 8'hFF);
        str = 1'b0;
        tick();
        f0 = frames;
        send(4, 3);
        send(3, 4);
        str = 1'b1;
        sb.push_back(ref_modexp(1, 1, 255));
        expect_frame("busy", 4);
        repeat (40) tick();
        chk("busy_once", frames, f0 + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sam_decoder.md
Name: sam_decoder

Overview:
- Serial "SAM" RSA-style decoder with a single input line `str`.
- While `mode`=1 it shifts in a configuration: message length n, private exponent d, and modulus N.
- While `mode`=0 it decodes pulse-width-encoded message bits from `str`, collects an n-bit value m, and computes r = m^d mod N.
- It emits r serially on `msg`, with `frame` marking the valid bits. It sits between the line receiver and the downstream consumer.

Parameters:
- KEY_W, 8, width of d, N and the result r.
- LEN_W, 4, width of the message-length field n (n ≤ 15).
- CNT_W, 5, width of the pulse-duration counters, which saturate at 2^CNT_W−1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- str  in  1  serial configuration / message line, sampled each rising clk edge.
- mode  in  1  1 = configuration shift-in, 0 = message decoding.
- msg  out  1  serial result data, MSB first.
- frame  out  1  high exactly while `msg` carries a valid result bit.

Behaviour:
- Reset (reset=1 at a clk edge):
  - `msg`=0, `frame`=0.
  - n, d and N cleared; all counters cleared.
  - Decoder in IDLE; any computation or transmission aborted.
  - Previous-str register set to 1.
- Configuration, every edge with mode=1:
  - Shift `str` into the config chain, MSB first. The first 4 sampled bits are n, the next KEY_W are d, the next KEY_W are N.
  - Bits beyond 4+2*KEY_W are ignored.
  - The config bit counter clears whenever mode=0.
  - mode=1 aborts any decode, computation or output: `frame`=0, `msg`=0.
- Edge detection: prev_str is registered every cycle. A rising edge means sampled str=1 with prev_str=0. After mode falls, a level of 1 alone never counts as an edge.
- Decoder states: IDLE → HIGH → LOW → (HIGH ...).
  - IDLE: wait for a rising edge with mode=0. Then H=1, L=0, bit index=0, go to HIGH.
  - HIGH: H++ each cycle str=1. On the first str=0, L=1 and go to LOW.
  - LOW: L++ each cycle str=0. Counters saturate at 31.
- Bit close: a bit closes at the next rising edge.
  - Bit value = (H > L).
  - H == L means the bit is invalid: discard the partial message and restart collection with this edge as bit 1.
  - On a valid bit, shift it into m (MSB first), then start a new bit with H=1, L=0.
- Message completion:
  - When the n-th bit closes, m is complete. That closing edge also starts bit 1 of the next message.
  - n=0: decoding is disabled and the decoder stays IDLE.
- Modular exponentiation (sub-module):
  - Completion at edge T.
  - T+1: base = m mod N, r = 1 mod N.
  - T+2 .. T+1+KEY_W: one right-to-left square-and-multiply step per cycle, d LSB first. If d[i]=1 then r = r*base mod N; always base = base*base mod N.
  - Intermediates are 2*KEY_W bits wide.
  - N=0 or N=1 gives r=0.
- Output:
  - For cycles T+2+KEY_W .. T+1+2*KEY_W: `frame`=1 and `msg` = r[KEY_W-1] down to r[0].
  - Otherwise `frame`=0 and `msg`=0.
- Busy: a message completing while computing or transmitting is dropped. The current output is not disturbed, and decoding of later bits continues.
- Reconfiguration: a new config takes effect for messages whose first bit starts after mode falls.

Decomposition:
- sam_pkg holds KEY_W, LEN_W, CNT_W, the decoder state enum {IDLE, HIGH, LOW}, and the engine state enum {E_IDLE, E_LOAD, E_RUN, E_OUT}.
- One sub-module, sam_modexp, implements the load/run/serial-out engine with a start pulse and m, d, N inputs, driving `msg` and `frame`.
- The top level holds the config shifter, edge detect and pulse decoder.

Test Plan:
- Config n=3, d=0xFF, N=0xFF (20 mode cycles). Send pulses of 17 high / 10 low as bits 1,1,1, then a 4th rising edge → `frame` high 8 cycles starting 10 cycles after that edge, `msg` = 0x49 (7^255 mod 255).
- Config n=3, d=0x03, N=0x0D. Bits 1,0,1 (12H/6L, 6H/12L, 12H/6L) plus a closing edge → `msg` = 0x08 (125 mod 13).
- Bit with H=8, L=8 in the middle of a message → no `frame`. The next 3 valid bits plus a closing edge produce a result.
- Reset asserted during `frame` → `frame`=0 and `msg`=0 next cycle. No further output until reconfiguration and a new message.
- N=0x01, any message → `frame` pulses 8 cycles with `msg` = 0x00.
- Last config bit of N = 1 followed by str held high one extra cycle after mode falls → no rising edge detected and no spurious bit.
